// File: rtl/camera_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : camera_state_ctrl
// Brief    : Frame sequencer for the 2x2 pixel camera (Idle -> Exposure ->
//            Readout -> Idle). Drives the pixel array controls, Busy and Frame_done.
// Revision : 1.0 - initial release
// ============================================================================
module camera_state_ctrl #(
  parameter int EXP_W   = 5,
  parameter int EXP_MIN = 2,
  parameter int EXP_MAX = 30,
  parameter int NRE_LEN = 3,
  parameter int ADC_POS = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic [EXP_W-1:0] EX_time,
  output logic             Erase,
  output logic             Expose,
  output logic             NRE_1,
  output logic             NRE_2,
  output logic             ADC,
  output logic             Busy,
  output logic             Frame_done
);

  localparam int RD_W = $clog2(2*NRE_LEN+2);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_EXPOSE  = 2'd1;
  localparam logic [1:0] c_ST_READOUT = 2'd2;

  localparam logic [EXP_W-1:0] c_EXP_MIN = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] c_EXP_MAX = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] c_EXP_ONE = EXP_W'(1);

  localparam logic [RD_W-1:0] c_RD_ONE        = RD_W'(1);
  localparam logic [RD_W-1:0] c_RD_NRE1_END   = RD_W'(NRE_LEN-1);
  localparam logic [RD_W-1:0] c_RD_NRE2_START = RD_W'(NRE_LEN+1);
  localparam logic [RD_W-1:0] c_RD_NRE2_END   = RD_W'(2*NRE_LEN);
  localparam logic [RD_W-1:0] c_RD_LAST       = RD_W'(2*NRE_LEN+1);
  localparam logic [RD_W-1:0] c_RD_ADC1       = RD_W'(ADC_POS);
  localparam logic [RD_W-1:0] c_RD_ADC2       = RD_W'(NRE_LEN+1+ADC_POS);

  logic [1:0]       r_state;
  logic [EXP_W-1:0] r_exp_len;
  logic [EXP_W-1:0] r_exp_cnt;
  logic [RD_W-1:0]  r_rd_cnt;
  logic             r_done_pending;

  logic [1:0]       w_state_nxt;
  logic [EXP_W-1:0] w_exp_len_nxt;
  logic [EXP_W-1:0] w_exp_cnt_nxt;
  logic [RD_W-1:0]  w_rd_cnt_nxt;
  logic             w_done_pending_nxt;
  logic [EXP_W-1:0] w_exp_clamped;
  logic             w_exp_last;
  logic             w_rd_last;

  logic r_erase, r_expose, r_nre_1, r_nre_2, r_adc, r_busy, r_frame_done;
  logic w_erase, w_expose, w_nre_1, w_nre_2, w_adc, w_busy, w_frame_done;

  always_comb begin
    w_exp_clamped = EX_time;
    if (EX_time < c_EXP_MIN) begin
      w_exp_clamped = c_EXP_MIN;
    end else if (EX_time > c_EXP_MAX) begin
      w_exp_clamped = c_EXP_MAX;
    end
  end

  // Exposure length is at least EXP_MIN (>=2), so the subtraction cannot underflow.
  assign w_exp_last = (r_exp_cnt == (r_exp_len - c_EXP_ONE));
  assign w_rd_last  = (r_rd_cnt == c_RD_LAST);

  always_comb begin
    w_state_nxt        = r_state;
    w_exp_len_nxt      = r_exp_len;
    w_exp_cnt_nxt      = r_exp_cnt;
    w_rd_cnt_nxt       = r_rd_cnt;
    w_done_pending_nxt = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (Init) begin
          w_state_nxt   = c_ST_EXPOSE;
          w_exp_len_nxt = w_exp_clamped;
          w_exp_cnt_nxt = '0;
        end
      end
      c_ST_EXPOSE: begin
        if (w_exp_last) begin
          w_state_nxt   = c_ST_READOUT;
          w_exp_cnt_nxt = '0;
          w_rd_cnt_nxt  = '0;
        end else begin
          w_exp_cnt_nxt = r_exp_cnt + c_EXP_ONE;
        end
      end
      c_ST_READOUT: begin
        if (w_rd_last) begin
          w_state_nxt        = c_ST_IDLE;
          w_rd_cnt_nxt       = '0;
          w_done_pending_nxt = 1'b1;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + c_RD_ONE;
        end
      end
      default: begin
        w_state_nxt   = c_ST_IDLE;
        w_exp_cnt_nxt = '0;
        w_rd_cnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= c_ST_IDLE;
      r_exp_len      <= c_EXP_MIN;
      r_exp_cnt      <= '0;
      r_rd_cnt       <= '0;
      r_done_pending <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_exp_len      <= w_exp_len_nxt;
      r_exp_cnt      <= w_exp_cnt_nxt;
      r_rd_cnt       <= w_rd_cnt_nxt;
      r_done_pending <= w_done_pending_nxt;
    end
  end

  // Pixel controls are decoded from the current state and registered, so they
  // trail the state register by one cycle and never see Init combinationally.
  always_comb begin
    w_erase      = 1'b0;
    w_expose     = 1'b0;
    w_nre_1      = 1'b1;
    w_nre_2      = 1'b1;
    w_adc        = 1'b0;
    w_busy       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      c_ST_EXPOSE: begin
        w_expose = 1'b1;
        w_busy   = 1'b1;
      end
      c_ST_READOUT: begin
        w_busy  = 1'b1;
        w_nre_1 = !(r_rd_cnt <= c_RD_NRE1_END);
        w_nre_2 = !((r_rd_cnt >= c_RD_NRE2_START) && (r_rd_cnt <= c_RD_NRE2_END));
        w_adc   = (r_rd_cnt == c_RD_ADC1) || (r_rd_cnt == c_RD_ADC2);
      end
      default: begin
        w_erase      = 1'b1;
        w_frame_done = r_done_pending;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_erase      <= 1'b1;
      r_expose     <= 1'b0;
      r_nre_1      <= 1'b1;
      r_nre_2      <= 1'b1;
      r_adc        <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_erase      <= w_erase;
      r_expose     <= w_expose;
      r_nre_1      <= w_nre_1;
      r_nre_2      <= w_nre_2;
      r_adc        <= w_adc;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
    end
  end

  assign Erase      = r_erase;
  assign Expose     = r_expose;
  assign NRE_1      = r_nre_1;
  assign NRE_2      = r_nre_2;
  assign ADC        = r_adc;
  assign Busy       = r_busy;
  assign Frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_camera_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_camera_state_ctrl
// Brief    : Directed self-checking bench for camera_state_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camera_state_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Init = 1'b0;
  logic [4:0] EX_time = 5'd10;
  logic       Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] c_IDLE_VEC = 7'b1011000;

  camera_state_ctrl #(
    .EXP_W(5), .EXP_MIN(2), .EXP_MAX(30), .NRE_LEN(3), .ADC_POS(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Init(Init), .EX_time(EX_time),
    .Erase(Erase), .Expose(Expose), .NRE_1(NRE_1), .NRE_2(NRE_2),
    .ADC(ADC), .Busy(Busy), .Frame_done(Frame_done)
  );

  always #5 Clk = ~Clk;

  // Expected {Erase,Expose,NRE_1,NRE_2,ADC,Busy,Frame_done} at cycle k of a
  // frame whose Init was sampled at edge 0, exposure length t, NRE_LEN = 3.
  function automatic logic [6:0] exp_vec(input int k, input int t);
    int   rd;
    logic e, x, n1, n2, a, b, f;
    e = 1'b0; x = 1'b0; n1 = 1'b1; n2 = 1'b1; a = 1'b0; b = 1'b0; f = 1'b0;
    if (k >= 1 && k <= t) begin
      x = 1'b1;
      b = 1'b1;
    end else if (k > t && k <= t + 8) begin
      rd = k - t - 1;
      b  = 1'b1;
      n1 = !(rd <= 2);
      n2 = !(rd >= 4 && rd <= 6);
      a  = (rd == 1) || (rd == 5);
    end else begin
      e = 1'b1;
      f = (k == t + 9);
    end
    return {e, x, n1, n2, a, b, f};
  endfunction

  function automatic logic [6:0] outs();
    return {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_done};
  endfunction

  // Called at #1 after an edge; returns at #1 after the edge that sampled Init.
  task automatic start_frame(input logic [4:0] ex, input bit hold);
    EX_time = ex;
    Init    = 1'b1;
    @(posedge Clk); #1;
    if (!hold) Init = 1'b0;
  endtask

  task automatic run_frame(input string name, input int t, input int ncyc,
                           input int hi_at, input int lo_at,
                           input int chg_at, input logic [4:0] chg_val);
    logic [6:0] got, want;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge Clk); #1;
      got  = outs();
      want = exp_vec(k, t);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, k, got, want);
      end
      if (k == chg_at) EX_time = chg_val;
      if (k == hi_at)  Init = 1'b1;
      if (k == lo_at)  Init = 1'b0;
    end
  endtask

  task automatic check_idle(input string name, input int ncyc);
    logic [6:0] got;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge Clk); #1;
      got = outs();
      n_checks++;
      if (got !== c_IDLE_VEC) begin
        n_fail++;
        $display("FAIL %s idle cycle %0d: got %b expected %b", name, k, got, c_IDLE_VEC);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Init  = 1'b0;
    check_idle("reset_held", 3);
    Reset = 1'b0;
    check_idle("post_reset", 4);
  endtask

  task automatic test_basic_frame();
    start_frame(5'd10, 1'b0);
    run_frame("basic_t10", 10, 19, -1, -1, -1, 5'd0);
    check_idle("basic_after", 2);
  endtask

  task automatic test_clamp();
    start_frame(5'd0, 1'b0);
    run_frame("clamp_low_0", 2, 11, -1, -1, -1, 5'd0);
    check_idle("clamp_low_after", 1);
    start_frame(5'd1, 1'b0);
    run_frame("clamp_low_1", 2, 11, -1, -1, -1, 5'd0);
    check_idle("clamp_low1_after", 1);
    start_frame(5'd31, 1'b0);
    run_frame("clamp_high_31", 30, 39, -1, -1, -1, 5'd0);
    check_idle("clamp_high_after", 1);
    start_frame(5'd30, 1'b0);
    run_frame("exact_max_30", 30, 39, -1, -1, -1, 5'd0);
    check_idle("exact_max_after", 1);
  endtask

  task automatic test_ignore_inputs();
    // EX_time changed at exposure cycle 4; Init pulsed while reading out.
    start_frame(5'd10, 1'b0);
    run_frame("ignore_inputs", 10, 19, 13, 14, 4, 5'd25);
    check_idle("no_second_frame", 6);
  endtask

  task automatic test_back_to_back();
    start_frame(5'd10, 1'b1);
    run_frame("b2b_frame1", 10, 19, -1, -1, -1, 5'd0);
    run_frame("b2b_frame2", 10, 19, -1, -1, -1, 5'd0);
    run_frame("b2b_frame3", 10, 19, -1, 18, -1, 5'd0);
    check_idle("b2b_after", 3);
  endtask

  task automatic test_reset_mid();
    start_frame(5'd10, 1'b0);
    run_frame("rst_mid_exp", 10, 5, -1, -1, -1, 5'd0);
    Reset = 1'b1;
    check_idle("rst_mid_exp_now", 1);
    Reset = 1'b0;
    check_idle("rst_mid_exp_after", 20);
    start_frame(5'd10, 1'b0);
    run_frame("rst_mid_rd", 10, 13, -1, -1, -1, 5'd0);
    Reset = 1'b1;
    check_idle("rst_mid_rd_now", 1);
    Reset = 1'b0;
    check_idle("rst_mid_rd_after", 12);
    start_frame(5'd3, 1'b0);
    run_frame("after_resets", 3, 12, -1, -1, -1, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge Clk); #1;
    test_reset();
    test_basic_frame();
    test_clamp();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
